// File: rtl/riscv_mem_pkg.sv
// Shared memory-access encodings and LSU state enum for the data-side pipeline.
// The FAULT state exists only when LSU_MISALIGN_TRAP_EN is defined.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    MEM_DISABLE   = 2'b00,
    MEM_READ_SEXT = 2'b01,
    MEM_READ_ZEXT = 2'b10,
    MEM_WRITE     = 2'b11
  } mem_op_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
`ifdef LSU_MISALIGN_TRAP_EN
    ST_RESP,
    ST_FAULT
`else
    ST_RESP
`endif
  } lsu_state_e;

  // Size 2'b11 behaves as a word everywhere.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    if (size == SZ_HALF) return addrLo[0];
    if (size[1])         return addrLo != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] alignAddr(input logic [1:0] size, input logic [31:0] addr);
    if (size == SZ_BYTE) return addr;
    if (size == SZ_HALF) return {addr[31:1], 1'b0};
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and RAM port B bundle of the load/store unit.
// master = pipeline + RAM side, slave = the load/store unit itself.
interface load_store_unit_if;
  import riscv_mem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  mem_op_e     req_op;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_misaligned;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_web;
  logic [31:0] mem_dout;
  logic        mem_read_valid;
  logic        mem_not_ready;

  modport master (
    output req_valid, req_op, req_size, req_addr, req_wdata, req_rd,
           mem_dout, mem_read_valid, mem_not_ready,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_misaligned,
           mem_addr, mem_din, mem_web
  );

  modport slave (
    input  req_valid, req_op, req_size, req_addr, req_wdata, req_rd,
           mem_dout, mem_read_valid, mem_not_ready,
    output req_ready, resp_valid, resp_data, resp_rd, resp_misaligned,
           mem_addr, mem_din, mem_web
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables / lane replication and
// load shift plus sign/zero extension.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  stSize,
  input  logic [1:0]  stAddrLo,
  input  logic [31:0] stData,
  output logic [3:0]  stWeb,
  output logic [31:0] stDin,
  input  mem_op_e     ldOp,
  input  logic [1:0]  ldSize,
  input  logic [1:0]  ldAddrLo,
  input  logic [31:0] ldWord,
  output logic [31:0] ldData
);

  logic [31:0] ldShifted;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size,
                                         input logic sx);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = v[7:0];
    h = v[15:0];
    case (size)
      SZ_BYTE: extend = sx ? 32'(b) : {24'b0, v[7:0]};
      SZ_HALF: extend = sx ? 32'(h) : {16'b0, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  always_comb begin
    stWeb = 4'b1111;
    stDin = stData;
    case (stSize)
      SZ_BYTE: begin
        stWeb = 4'b0001 << stAddrLo;
        stDin = {4{stData[7:0]}};
      end
      SZ_HALF: begin
        stWeb = 4'b0011 << {stAddrLo[1], 1'b0};
        stDin = {2{stData[15:0]}};
      end
      default: ;
    endcase
  end

  assign ldShifted = ldWord >> {ldAddrLo, 3'b000};
  assign ldData    = extend(ldShifted, ldSize, ldOp == MEM_READ_SEXT);

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store unit between execute and data RAM port B.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module load_store_unit
  import riscv_mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);

  lsu_state_e  state, nextState;
  logic [1:0]  rstSync;
  logic        rstN;
  logic        accept, startIssue, issueDone, loadDone, respNow, faultNow;
  logic        reqMisaligned;
  logic [31:0] effAddr;
  logic [3:0]  stWeb;
  logic [31:0] stDin, ldData;
  mem_op_e     opQ;
  logic [1:0]  sizeQ, addrLoQ;
  logic [4:0]  rdQ;

`ifdef LSU_MISALIGN_TRAP_EN
  assign effAddr       = bus.req_addr;
  assign reqMisaligned = isMisaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign effAddr       = alignAddr(bus.req_size, bus.req_addr);
  assign reqMisaligned = 1'b0;
`endif

  // Reset asserts asynchronously, releases two clocks later in this domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rstSync <= 2'b00;
    else        rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  lsu_align uAlign (
    .stSize  (bus.req_size),
    .stAddrLo(effAddr[1:0]),
    .stData  (bus.req_wdata),
    .stWeb   (stWeb),
    .stDin   (stDin),
    .ldOp    (opQ),
    .ldSize  (sizeQ),
    .ldAddrLo(addrLoQ),
    .ldWord  (bus.mem_dout),
    .ldData  (ldData)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= ST_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (accept) nextState = reqMisaligned ? ST_FAULT : ST_ISSUE;
`else
        if (accept) nextState = ST_ISSUE;
`endif
      end
      ST_ISSUE: if (!bus.mem_not_ready) nextState = (opQ == MEM_WRITE) ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (bus.mem_read_valid) nextState = ST_RESP;
      ST_RESP:  nextState = ST_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
      ST_FAULT: nextState = ST_IDLE;
`endif
      default:  nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == ST_IDLE);
    accept        = bus.req_ready && bus.req_valid && (bus.req_op != MEM_DISABLE);
    startIssue    = accept && !reqMisaligned;
    issueDone     = (state == ST_ISSUE) && !bus.mem_not_ready;
    loadDone      = (state == ST_WAIT) && bus.mem_read_valid;
`ifdef LSU_MISALIGN_TRAP_EN
    faultNow      = (state == ST_FAULT);
`else
    faultNow      = 1'b0;
`endif
    respNow       = (state == ST_RESP) || faultNow;
  end

  // Registered outputs; resp_valid trails the RESP/FAULT state by one edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_rd    <= '0;
      bus.mem_addr   <= '0;
      bus.mem_din    <= '0;
      bus.mem_web    <= '0;
    end else begin
      bus.resp_valid <= respNow;
      if (respNow) bus.resp_rd <= rdQ;
      if (accept)        bus.resp_data <= '0;
      else if (loadDone) bus.resp_data <= ldData;
      if (startIssue) begin
        bus.mem_addr <= effAddr;
        bus.mem_din  <= stDin;
        bus.mem_web  <= (bus.req_op == MEM_WRITE) ? stWeb : 4'b0000;
      end else if (issueDone) begin
        bus.mem_web  <= '0;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) bus.resp_misaligned <= 1'b0;
    else       bus.resp_misaligned <= faultNow;
  end
`else
  assign bus.resp_misaligned = 1'b0;
`endif

  // Request fields needed after acceptance; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      opQ     <= bus.req_op;
      sizeQ   <= bus.req_size;
      addrLoQ <= effAddr[1:0];
      rdQ     <= bus.req_rd;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small byte-write RAM model on port B.
// Expectations for misaligned accesses follow LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;
  import riscv_mem_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        mis;
    int          cyc;
  } exp_t;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q[$];
  exp_t mon;
  logic [31:0] ram [256];

  load_store_unit_if bus();

  load_store_unit dut (
    .clk  (clk),
    .reset(resetN),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM port B: byte writes on web, registered read data.
  always @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (!bus.mem_not_ready) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_web[b]) ram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_din[8*b +: 8];
    end
    bus.mem_dout <= ram[bus.mem_addr[9:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rd %0d at cycle %0d expected no response", bus.resp_rd, cyc);
      end else begin
        mon = q.pop_front();
        chk("resp_data", bus.resp_data, mon.data);
        chk("resp_rd", 32'(bus.resp_rd), 32'(mon.rd));
        chk("resp_misaligned", 32'(bus.resp_misaligned), 32'(mon.mis));
        chk("resp_cycle", cyc, mon.cyc);
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready %b expected 1", bus.req_ready);
    end
  endtask

  task automatic issue(input mem_op_e op, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input int lat,
                       input logic [31:0] expData, input logic expMis, input bit expResp);
    exp_t e;
    waitReady();
    bus.req_op    = op;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_rd    = rd;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (expResp) begin
      e.data = expData;
      e.rd   = rd;
      e.mis  = expMis;
      e.cyc  = cyc + lat;
      q.push_back(e);
    end
  endtask

  task automatic st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [4:0] rd);
    issue(MEM_WRITE, size, addr, wdata, rd, 2, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic ld(input mem_op_e op, input logic [1:0] size, input logic [31:0] addr,
                    input logic [4:0] rd, input logic [31:0] expData);
    issue(op, size, addr, 32'h0, rd, 3, expData, 1'b0, 1'b1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_op         = MEM_DISABLE;
    bus.req_size       = SZ_BYTE;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.req_rd         = '0;
    bus.mem_not_ready  = 1'b0;
    bus.mem_read_valid = 1'b1;

    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_web", 32'(bus.mem_web), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_din", bus.mem_din, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_misaligned", 32'(bus.resp_misaligned), 32'd0);
    #2 resetN = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    st(SZ_BYTE, 32'h0000_0103, 32'h0000_00AB, 5'd1);
    @(negedge clk);
    chk("stb_web", 32'(bus.mem_web), 32'h8);
    chk("stb_din", bus.mem_din, 32'hABAB_ABAB);
    chk("stb_addr", bus.mem_addr, 32'h0000_0103);
    @(negedge clk);
    chk("stb_web_clear", 32'(bus.mem_web), 32'h0);

    st(SZ_WORD, 32'h0000_0200, 32'h80FF_7F01, 5'd5);
    @(negedge clk);
    chk("stw_web", 32'(bus.mem_web), 32'hF);
    ld(MEM_READ_SEXT, SZ_BYTE, 32'h0000_0202, 5'd2, 32'hFFFF_FFFF);
    ld(MEM_READ_ZEXT, SZ_BYTE, 32'h0000_0202, 5'd3, 32'h0000_00FF);

    st(SZ_WORD, 32'h0000_0300, 32'h8001_1234, 5'd14);
    ld(MEM_READ_SEXT, SZ_HALF, 32'h0000_0302, 5'd4, 32'hFFFF_8001);
    ld(MEM_READ_ZEXT, SZ_HALF, 32'h0000_0302, 5'd6, 32'h0000_8001);

    ld(MEM_READ_ZEXT, SZ_WORD, 32'h0000_0100, 5'd7, 32'hAB00_0000);
    ld(MEM_READ_ZEXT, SZ_BYTE, 32'h0000_0103, 5'd8, 32'h0000_00AB);
    ld(MEM_READ_SEXT, SZ_BYTE, 32'h0000_0103, 5'd9, 32'hFFFF_FFAB);

    st(SZ_WORD, 32'h0000_0204, 32'h1111_1111, 5'd15);
    st(SZ_HALF, 32'h0000_0206, 32'h1234_CDEF, 5'd16);
    @(negedge clk);
    chk("sth_web", 32'(bus.mem_web), 32'hC);
    chk("sth_din", bus.mem_din, 32'hCDEF_CDEF);
    ld(MEM_READ_ZEXT, SZ_WORD, 32'h0000_0204, 5'd10, 32'hCDEF_1111);
    st(SZ_BYTE, 32'h0000_0205, 32'h0000_0077, 5'd17);
    @(negedge clk);
    chk("stb1_web", 32'(bus.mem_web), 32'h2);
    ld(MEM_READ_ZEXT, SZ_WORD, 32'h0000_0204, 5'd11, 32'hCDEF_7711);
    ld(MEM_READ_ZEXT, 2'b11, 32'h0000_0204, 5'd18, 32'hCDEF_7711);

    st(SZ_WORD, 32'h0000_0004, 32'hDEAD_BEEF, 5'd19);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(MEM_READ_SEXT, SZ_WORD, 32'h0000_0006, 32'h0, 5'd20, 1, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    chk("mis_ld_web", 32'(bus.mem_web), 32'h0);
    issue(MEM_WRITE, SZ_WORD, 32'h0000_0006, 32'h5566_7788, 5'd21, 1, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    chk("mis_st_web", 32'(bus.mem_web), 32'h0);
    ld(MEM_READ_ZEXT, SZ_WORD, 32'h0000_0004, 5'd22, 32'hDEAD_BEEF);
    issue(MEM_READ_SEXT, SZ_HALF, 32'h0000_0301, 32'h0, 5'd26, 1, 32'h0, 1'b1, 1'b1);
`else
    ld(MEM_READ_SEXT, SZ_WORD, 32'h0000_0006, 5'd20, 32'hDEAD_BEEF);
    st(SZ_WORD, 32'h0000_0006, 32'h5566_7788, 5'd21);
    @(negedge clk);
    chk("mis_st_web", 32'(bus.mem_web), 32'hF);
    chk("mis_st_addr", bus.mem_addr, 32'h0000_0004);
    ld(MEM_READ_ZEXT, SZ_WORD, 32'h0000_0004, 5'd22, 32'h5566_7788);
    ld(MEM_READ_SEXT, SZ_HALF, 32'h0000_0301, 5'd26, 32'h0000_1234);
`endif

    waitReady();
    bus.req_op    = MEM_DISABLE;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("disable_ready", 32'(bus.req_ready), 32'd1);

    bus.mem_not_ready = 1'b1;
    issue(MEM_WRITE, SZ_WORD, 32'h0000_0008, 32'hA5A5_A5A5, 5'd12, 4, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("stall_web0", 32'(bus.mem_web), 32'hF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_web1", 32'(bus.mem_web), 32'hF);
    chk("stall_addr1", bus.mem_addr, 32'h0000_0008);
    @(posedge clk); #1;
    chk("stall_web2", 32'(bus.mem_web), 32'hF);
    chk("stall_addr2", bus.mem_addr, 32'h0000_0008);
    bus.mem_not_ready = 1'b0;

    bus.mem_read_valid = 1'b0;
    issue(MEM_READ_ZEXT, SZ_WORD, 32'h0000_0008, 32'h0, 5'd13, 4, 32'hA5A5_A5A5, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_read_valid = 1'b1;
    waitDrain();

    bus.mem_not_ready = 1'b1;
    issue(MEM_WRITE, SZ_WORD, 32'h0000_0010, 32'h1234_5678, 5'd24, 0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_issue_web", 32'(bus.mem_web), 32'hF);
    #2 resetN = 1'b0;
    #1;
    chk("rst_async_web", 32'(bus.mem_web), 32'h0);
    chk("rst_async_valid", 32'(bus.resp_valid), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    bus.mem_not_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_release_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_release_web", 32'(bus.mem_web), 32'h0);
    ld(MEM_READ_ZEXT, SZ_WORD, 32'h0000_0010, 5'd25, 32'h0);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
